// File: rtl/mvb_fifo_checker_if.sv
// Write-side (RX) and read-side (TX) MVB buses of a multi-port FIFO.
// The checker observes every signal through the slave modport.
interface mvb_fifo_checker_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 2
);
  logic [WRITE_PORTS*DATA_WIDTH-1:0] RX_DATA;
  logic [WRITE_PORTS-1:0]            RX_VLD;
  logic                              RX_SRC_RDY;
  logic                              RX_DST_RDY;
  logic [READ_PORTS*DATA_WIDTH-1:0]  TX_DATA;
  logic [READ_PORTS-1:0]             TX_VLD;
  logic                              TX_SRC_RDY;
  logic                              TX_DST_RDY;

  modport master (
    output RX_DATA, RX_VLD, RX_SRC_RDY, RX_DST_RDY,
    output TX_DATA, TX_VLD, TX_SRC_RDY, TX_DST_RDY
  );

  modport slave (
    input RX_DATA, RX_VLD, RX_SRC_RDY, RX_DST_RDY,
    input TX_DATA, TX_VLD, TX_SRC_RDY, TX_DST_RDY
  );
endinterface

// File: rtl/mvb_fifo_checker.sv
// Observe-only run-time checker for a multi-port MVB FIFO: hold/empty rule
// checks on both buses, occupancy tracking with overflow/underflow detection,
// item counters and a first-error record. All outputs are registered.
module mvb_fifo_checker #(
  parameter int DATA_WIDTH  = 16,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 2,
  parameter int ITEMS       = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  mvb_fifo_checker_if.slave          BUS,
  input  logic                       ERR_CLR,
  output logic [5:0]                 ERR_FLAGS,
  output logic                       ERR_PULSE,
  output logic [5:0]                 FIRST_ERR,
  output logic [CNT_WIDTH-1:0]       FIRST_TIME,
  output logic [$clog2(ITEMS+1)-1:0] OCCUPANCY,
  output logic [CNT_WIDTH-1:0]       RX_ITEM_CNT,
  output logic [CNT_WIDTH-1:0]       TX_ITEM_CNT
);

  localparam int OCC_W = $clog2(ITEMS + 1);
  localparam int RXW   = WRITE_PORTS * DATA_WIDTH;
  localparam int TXW   = READ_PORTS * DATA_WIDTH;

  typedef enum logic {HOLD_IDLE, HOLD_STALLED} hold_state_e;

  hold_state_e            rx_state_q, rx_state_d;
  hold_state_e            tx_state_q, tx_state_d;
  logic [RXW-1:0]         rx_data_q;
  logic [WRITE_PORTS-1:0] rx_vld_q;
  logic [TXW-1:0]         tx_data_q;
  logic [READ_PORTS-1:0]  tx_vld_q;
  logic                   rx_hold_viol, tx_hold_viol;
  logic                   rx_empty_viol, tx_empty_viol;

  logic [OCC_W-1:0]       occ_q, occ_d, occ_left;
  logic [OCC_W:0]         occ_sum;
  logic [OCC_W-1:0]       rx_items, tx_items;
  logic                   overflow, underflow;

  logic [5:0]             viol;
  logic [5:0]             flags_q, flags_d, first_q, first_d, first_base;
  logic                   pulse_q;
  logic [CNT_WIDTH-1:0]   time_q, time_d, time_base;
  logic [CNT_WIDTH-1:0]   cyc_q, rx_cnt_q, tx_cnt_q;

  // Hold-tracking state and the last-seen bus words for the hold comparison
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_state_q <= HOLD_IDLE;
      tx_state_q <= HOLD_IDLE;
      rx_data_q  <= '0;
      rx_vld_q   <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_data_q  <= BUS.RX_DATA;
      rx_vld_q   <= BUS.RX_VLD;
      tx_data_q  <= BUS.TX_DATA;
      tx_vld_q   <= BUS.TX_VLD;
    end
  end

  // Stall detection and hold/empty rule checks for both buses
  always_comb begin
    rx_state_d   = HOLD_IDLE;
    tx_state_d   = HOLD_IDLE;
    rx_hold_viol = 1'b0;
    tx_hold_viol = 1'b0;
    if (BUS.RX_SRC_RDY && !BUS.RX_DST_RDY) rx_state_d = HOLD_STALLED;
    if (BUS.TX_SRC_RDY && !BUS.TX_DST_RDY) tx_state_d = HOLD_STALLED;
    if (rx_state_q == HOLD_STALLED) begin
      if (!BUS.RX_SRC_RDY || (BUS.RX_VLD != rx_vld_q)) rx_hold_viol = 1'b1;
      for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
        if (rx_vld_q[i] && (BUS.RX_DATA[i*DATA_WIDTH +: DATA_WIDTH]
                            != rx_data_q[i*DATA_WIDTH +: DATA_WIDTH]))
          rx_hold_viol = 1'b1;
      end
    end
    if (tx_state_q == HOLD_STALLED) begin
      if (!BUS.TX_SRC_RDY || (BUS.TX_VLD != tx_vld_q)) tx_hold_viol = 1'b1;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
        if (tx_vld_q[i] && (BUS.TX_DATA[i*DATA_WIDTH +: DATA_WIDTH]
                            != tx_data_q[i*DATA_WIDTH +: DATA_WIDTH]))
          tx_hold_viol = 1'b1;
      end
    end
    rx_empty_viol = BUS.RX_SRC_RDY && (BUS.RX_VLD == '0);
    tx_empty_viol = BUS.TX_SRC_RDY && (BUS.TX_VLD == '0);
  end

  // Occupancy update: reads drain only what was already stored, then writes land
  always_comb begin
    rx_items  = (BUS.RX_SRC_RDY && BUS.RX_DST_RDY) ? OCC_W'($countones(BUS.RX_VLD)) : '0;
    tx_items  = (BUS.TX_SRC_RDY && BUS.TX_DST_RDY) ? OCC_W'($countones(BUS.TX_VLD)) : '0;
    underflow = tx_items > occ_q;
    occ_left  = underflow ? '0 : occ_q - tx_items;
    occ_sum   = {1'b0, occ_left} + {1'b0, rx_items};
    overflow  = occ_sum > (OCC_W + 1)'(ITEMS);
    occ_d     = overflow ? OCC_W'(ITEMS) : occ_sum[OCC_W-1:0];
  end

  // Sticky flags and first-error capture; a same-cycle violation beats ERR_CLR
  always_comb begin
    viol       = {underflow, overflow, tx_empty_viol, tx_hold_viol, rx_empty_viol, rx_hold_viol};
    flags_d    = (ERR_CLR ? '0 : flags_q) | viol;
    first_base = ERR_CLR ? '0 : first_q;
    time_base  = ERR_CLR ? '0 : time_q;
    first_d    = first_base;
    time_d     = time_base;
    if ((first_base == '0) && (viol != '0)) begin
      first_d = viol;
      time_d  = cyc_q;
    end
  end

  // Output and counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags_q  <= '0;
      pulse_q  <= 1'b0;
      first_q  <= '0;
      time_q   <= '0;
      occ_q    <= '0;
      cyc_q    <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      flags_q  <= flags_d;
      pulse_q  <= |viol;
      first_q  <= first_d;
      time_q   <= time_d;
      occ_q    <= occ_d;
      cyc_q    <= cyc_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(rx_items);
      tx_cnt_q <= tx_cnt_q + CNT_WIDTH'(tx_items);
    end
  end

  assign ERR_FLAGS   = flags_q;
  assign ERR_PULSE   = pulse_q;
  assign FIRST_ERR   = first_q;
  assign FIRST_TIME  = time_q;
  assign OCCUPANCY   = occ_q;
  assign RX_ITEM_CNT = rx_cnt_q;
  assign TX_ITEM_CNT = tx_cnt_q;

endmodule

// File: tb/tb_mvb_fifo_checker.sv
// Scoreboard bench for mvb_fifo_checker: a queue-based FIFO model predicts
// every registered output; a monitor compares on each falling edge.
module tb_mvb_fifo_checker;
  localparam int DW = 16;
  localparam int WP = 4;
  localparam int RP = 2;
  localparam int IT = 64;
  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ERR_CLR = 1'b0;
  logic [5:0]    ERR_FLAGS, FIRST_ERR;
  logic          ERR_PULSE;
  logic [CW-1:0] FIRST_TIME, RX_ITEM_CNT, TX_ITEM_CNT;
  logic [6:0]    OCCUPANCY;

  mvb_fifo_checker_if #(.DATA_WIDTH(DW), .WRITE_PORTS(WP), .READ_PORTS(RP)) bus ();

  mvb_fifo_checker #(
    .DATA_WIDTH(DW), .WRITE_PORTS(WP), .READ_PORTS(RP), .ITEMS(IT), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .BUS(bus), .ERR_CLR(ERR_CLR),
    .ERR_FLAGS(ERR_FLAGS), .ERR_PULSE(ERR_PULSE), .FIRST_ERR(FIRST_ERR),
    .FIRST_TIME(FIRST_TIME), .OCCUPANCY(OCCUPANCY),
    .RX_ITEM_CNT(RX_ITEM_CNT), .TX_ITEM_CNT(TX_ITEM_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]    flags;
    logic          pulse;
    logic [5:0]    ferr;
    logic [CW-1:0] ftime;
    int            occ;
    logic [CW-1:0] rxc;
    logic [CW-1:0] txc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus for the next cycle
  logic [63:0] rx_d = '0;
  logic [3:0]  rx_v = '0;
  bit          rx_s = 0, rx_r = 0;
  logic [31:0] tx_d = '0;
  logic [1:0]  tx_v = '0;
  bit          tx_s = 0, tx_r = 0;

  // Reference model state
  logic [15:0]   m_fifo[$];
  bit            m_rx_st, m_tx_st;
  logic [63:0]   m_rx_dp;
  logic [3:0]    m_rx_vp;
  logic [63:0]   m_tx_dp;
  logic [3:0]    m_tx_vp;
  logic [5:0]    m_flags, m_ferr;
  logic [CW-1:0] m_ftime, m_cyc, m_rxc, m_txc;

  function automatic bit hold_bad(bit st, bit src, logic [63:0] d, logic [63:0] dp,
                                  logic [3:0] v, logic [3:0] vp, int n);
    if (!st) return 0;
    if (!src || v != vp) return 1;
    for (int i = 0; i < n; i++)
      if (vp[i] && d[i*16 +: 16] != dp[i*16 +: 16]) return 1;
    return 0;
  endfunction

  task automatic model(input bit rst, input bit clr);
    exp_t       e;
    logic [5:0] viol;
    int         ri, ti;
    if (rst) begin
      m_fifo.delete();
      m_rx_st = 0; m_tx_st = 0;
      m_flags = '0; m_ferr = '0; m_ftime = '0; m_cyc = '0; m_rxc = '0; m_txc = '0;
      e = '{flags: '0, pulse: 0, ferr: '0, ftime: '0, occ: 0, rxc: '0, txc: '0};
      sb.push_back(e);
      return;
    end
    viol = '0;
    viol[0] = hold_bad(m_rx_st, rx_s, rx_d, m_rx_dp, rx_v, m_rx_vp, WP);
    viol[1] = rx_s && (rx_v == 0);
    viol[2] = hold_bad(m_tx_st, tx_s, {32'h0, tx_d}, m_tx_dp, {2'b00, tx_v}, m_tx_vp, RP);
    viol[3] = tx_s && (tx_v == 0);
    ri = (rx_s && rx_r) ? $countones(rx_v) : 0;
    ti = (tx_s && tx_r) ? $countones(tx_v) : 0;
    // reads consume stored items only
    if (ti > m_fifo.size()) viol[5] = 1;
    for (int k = 0; k < ti; k++) if (m_fifo.size() > 0) void'(m_fifo.pop_front());
    for (int k = 0; k < WP; k++) begin
      if (ri > 0 && rx_v[k]) begin
        if (m_fifo.size() >= IT) viol[4] = 1;
        else m_fifo.push_back(rx_d[k*16 +: 16]);
      end
    end
    m_rxc += ri;
    m_txc += ti;
    if (clr) begin m_flags = '0; m_ferr = '0; m_ftime = '0; end
    m_flags |= viol;
    if (m_ferr == 0 && viol != 0) begin m_ferr = viol; m_ftime = m_cyc; end
    m_cyc++;
    m_rx_st = rx_s && !rx_r; m_rx_dp = rx_d; m_rx_vp = rx_v;
    m_tx_st = tx_s && !tx_r; m_tx_dp = {32'h0, tx_d}; m_tx_vp = {2'b00, tx_v};
    e = '{flags: m_flags, pulse: (viol != 0), ferr: m_ferr, ftime: m_ftime,
          occ: m_fifo.size(), rxc: m_rxc, txc: m_txc};
    sb.push_back(e);
  endtask

  task automatic tick(input bit rst, input bit clr);
    RESET = rst; ERR_CLR = clr;
    bus.RX_DATA = rx_d; bus.RX_VLD = rx_v; bus.RX_SRC_RDY = rx_s; bus.RX_DST_RDY = rx_r;
    bus.TX_DATA = tx_d; bus.TX_VLD = tx_v; bus.TX_SRC_RDY = tx_s; bus.TX_DST_RDY = tx_r;
    @(posedge CLK); #1;
    model(rst, clr);
  endtask

  task automatic idle();
    rx_s = 0; rx_r = 1; rx_v = '0; tx_s = 0; tx_r = 1; tx_v = '0;
  endtask

  task automatic rx_word(input logic [3:0] v, input bit src, input bit dst);
    rx_v = v; rx_s = src; rx_r = dst; rx_d = {$urandom, $urandom};
  endtask

  task automatic tx_word(input logic [1:0] v, input bit src, input bit dst);
    tx_v = v; tx_s = src; tx_r = dst; tx_d = $urandom;
  endtask

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: outputs are valid every cycle, one expectation per clocked cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ERR_FLAGS",   64'(ERR_FLAGS),   64'(e.flags));
        chk("ERR_PULSE",   64'(ERR_PULSE),   64'(e.pulse));
        chk("FIRST_ERR",   64'(FIRST_ERR),   64'(e.ferr));
        chk("FIRST_TIME",  64'(FIRST_TIME),  64'(e.ftime));
        chk("OCCUPANCY",   64'(OCCUPANCY),   64'(e.occ));
        chk("RX_ITEM_CNT", 64'(RX_ITEM_CNT), 64'(e.rxc));
        chk("TX_ITEM_CNT", 64'(TX_ITEM_CNT), 64'(e.txc));
      end
    end
  end

  initial begin
    int budget;
    idle();
    tick(1, 0); tick(1, 0);
    tick(0, 0);
    // Legal traffic: 40 items in, 40 out
    for (int i = 0; i < 10; i++) begin rx_word(4'hF, 1, 1); tick(0, 0); end
    idle();
    for (int i = 0; i < 20; i++) begin tx_word(2'b11, 1, 1); tick(0, 0); end
    idle(); tick(0, 0);
    // RX stall with changed data on the next cycle
    rx_word(4'b0001, 1, 0); tick(0, 0);
    rx_d[0] = ~rx_d[0]; rx_r = 1; tick(0, 0);
    idle(); tick(0, 0); tick(0, 0);
    // Underflow at occupancy 1, then an empty RX word
    tx_word(2'b11, 1, 1); tick(0, 0);
    idle(); rx_word(4'b0000, 1, 1); tick(0, 0);
    idle(); tick(0, 0);
    // Overflow from 62
    tick(1, 0);
    for (int i = 0; i < 15; i++) begin rx_word(4'hF, 1, 1); tick(0, 0); end
    rx_word(4'b0011, 1, 1); tick(0, 0);
    rx_word(4'hF, 1, 1); tick(0, 0);
    idle(); tick(0, 0);
    // Simultaneous read/write at 62 lands exactly on capacity
    tick(1, 0);
    for (int i = 0; i < 15; i++) begin rx_word(4'hF, 1, 1); tick(0, 0); end
    rx_word(4'b0011, 1, 1); tick(0, 0);
    rx_word(4'hF, 1, 1); tx_word(2'b11, 1, 1); tick(0, 0);
    idle(); tick(0, 0);
    // ERR_CLR coinciding with a TX hold violation
    rx_word(4'b0000, 1, 0); tick(0, 0);
    idle(); tx_word(2'b11, 1, 0); tick(0, 0);
    tx_d = ~tx_d; tick(0, 1);
    idle(); tick(0, 0); tick(0, 0);
    // Reset during a stall discards the pending hold check
    rx_word(4'hF, 1, 0); tick(0, 0);
    tick(1, 0);
    rx_d = ~rx_d; rx_r = 1; tick(0, 0);
    idle(); tick(0, 0);
    // Randomized traffic, mostly legal with occasional rule breaks
    for (int c = 0; c < 3000; c++) begin
      bit rst = ($urandom_range(0, 299) == 0);
      bit clr = ($urandom_range(0, 59) == 0);
      if (m_rx_st && $urandom_range(0, 99) < 85) begin
        rx_s = 1; rx_r = ($urandom_range(0, 3) != 0);
      end else begin
        rx_word(($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                ($urandom_range(0, 3) != 0),
                (m_fifo.size() <= IT - WP) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 19) == 0));
      end
      if (m_tx_st && $urandom_range(0, 99) < 85) begin
        tx_s = 1; tx_r = ($urandom_range(0, 3) != 0);
      end else begin
        tx_word(($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                (m_fifo.size() >= RP) ? ($urandom_range(0, 4) != 0)
                                      : ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0));
      end
      tick(rst, clr);
    end
    idle(); tick(0, 0);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin @(negedge CLK); budget--; end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
